// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported word memory between the fetch (I) and data (D)
// ports: one access per grant, fixed priority with a starvation guard.
module mem_port_arbiter #(
  parameter int DATA_PRIO    = 1,
  parameter int STARVE_LIMIT = 3,
  parameter int MEM_AW       = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          owner_q, owner_d;  // 1 = D owns the access in flight
  logic          err_q, err_d;
  logic          mem_ren_q, mem_ren_d;
  logic          mem_wen_q, mem_wen_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          i_done_q, i_done_d;
  logic          d_done_q, d_done_d;
  logic          i_err_q, i_err_d;
  logic          d_err_q, d_err_d;

  logic          grant_slot;
  logic          hi_req, lo_req;
  logic          starved, starve_sat;
  logic          lo_win, hi_win;
  logic          i_win, d_win;
  logic [31:0]   sel_addr;
  logic          sel_we;
  logic          in_range;

  // Handshake: a port's request is accepted on the posedge where x_req and
  // x_ready are both high; x_ready is only offered in IDLE/DONE slots, so the
  // requester must hold its fields stable until it sees x_ready.
  always_comb begin
    grant_slot = (state_q == IDLE) || (state_q == DONE);
    hi_req     = (DATA_PRIO != 0) ? d_req : i_req;
    lo_req     = (DATA_PRIO != 0) ? i_req : d_req;
    starve_sat = (starve_q == STARVE_MAX);
    starved    = (STARVE_LIMIT != 0) && starve_sat;
    lo_win     = grant_slot && lo_req && (!hi_req || starved);
    hi_win     = grant_slot && hi_req && !lo_win;
    d_win      = (DATA_PRIO != 0) ? hi_win : lo_win;
    i_win      = (DATA_PRIO != 0) ? lo_win : hi_win;
    sel_addr   = d_win ? d_addr : i_addr;
    sel_we     = d_win && d_we;
    in_range   = ((sel_addr >> MEM_AW) == 32'd0);
  end

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    owner_d   = owner_q;
    err_d     = err_q;
    mem_ren_d = 1'b0;
    mem_wen_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    i_err_d   = 1'b0;
    d_err_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (lo_win) begin
          starve_d = '0;
        end else if (lo_req && hi_req && !starve_sat) begin
          starve_d = starve_q + 1'b1;
        end

        if (i_win || d_win) begin
          state_d   = ACCESS;
          addr_d    = sel_addr;
          we_d      = sel_we;
          owner_d   = d_win;
          err_d     = !in_range;
          mem_ren_d = !sel_we && in_range;
          mem_wen_d = sel_we && in_range;
          if (d_win) begin
            wdata_d = d_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ACCESS: begin
        state_d = DONE;
        // Only a successful read updates the owner's rdata.
        if (owner_q) begin
          d_done_d = 1'b1;
          d_err_d  = err_q;
          if (!we_q && !err_q) begin
            d_rdata_d = mem_dout;
          end
        end else begin
          i_done_d = 1'b1;
          i_err_d  = err_q;
          if (!we_q && !err_q) begin
            i_rdata_d = mem_dout;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      owner_q   <= 1'b0;
      err_q     <= 1'b0;
      mem_ren_q <= 1'b0;
      mem_wen_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      owner_q   <= owner_d;
      err_q     <= err_d;
      mem_ren_q <= mem_ren_d;
      mem_wen_q <= mem_wen_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_err_q   <= i_err_d;
      d_err_q   <= d_err_d;
    end
  end

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign i_ready   = i_win && !reset;
  assign d_ready   = d_win && !reset;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_err     = i_err_q;
  assign d_err     = d_err_q;
  assign mem_ren   = mem_ren_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = addr_q;
  assign mem_din   = wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural word memory
// (combinational read, write on negedge).
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_err;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Memory model with a preload port so only one process writes the array.
  logic [31:0] mem [0:1023];
  logic        pre_en   = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  assign mem_dout = mem[mem_addr[9:0]];

  always @(negedge clock) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_wen) mem[mem_addr[9:0]] <= mem_din;
  end

  mem_port_arbiter #(.DATA_PRIO(1), .STARVE_LIMIT(3), .MEM_AW(10)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .dbg_state(dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to the drive point of the next cycle (1 time unit after posedge).
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] v);
    pre_addr = a;
    pre_data = v;
    pre_en   = 1'b1;
    @(negedge clock);
    #1;
    pre_en   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_req = 1'b1; i_addr = 32'd5;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd3; d_wdata = 32'hFFFF_FFFF;
    step(); #1;
    n_vec++; if (i_ready !== 1'b0) begin n_err++; $display("FAIL rst_i_ready got=%h exp=0", i_ready); end
    n_vec++; if (d_ready !== 1'b0) begin n_err++; $display("FAIL rst_d_ready got=%h exp=0", d_ready); end
    n_vec++; if ({mem_ren, mem_wen, i_done, d_done, i_err, d_err} !== 6'b0) begin
      n_err++; $display("FAIL rst_flags got=%b exp=000000", {mem_ren, mem_wen, i_done, d_done, i_err, d_err}); end
    n_vec++; if ({mem_addr, mem_din, i_rdata, d_rdata} !== 128'd0) begin
      n_err++; $display("FAIL rst_data got=%h exp=0", {mem_addr, mem_din, i_rdata, d_rdata}); end
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_i_read();
    i_req = 1'b1; i_addr = 32'd5; #1;
    n_vec++; if ({i_ready, d_ready} !== 2'b10) begin n_err++; $display("FAIL t1_ready got=%b exp=10", {i_ready, d_ready}); end
    step(); i_req = 1'b0; #1;
    n_vec++; if ({mem_ren, mem_wen} !== 2'b10) begin n_err++; $display("FAIL t1_ren got=%b exp=10", {mem_ren, mem_wen}); end
    n_vec++; if (mem_addr !== 32'd5) begin n_err++; $display("FAIL t1_addr got=%h exp=5", mem_addr); end
    n_vec++; if (i_ready !== 1'b0) begin n_err++; $display("FAIL t1_ready_access got=%h exp=0", i_ready); end
    step(); #1;
    n_vec++; if ({i_done, i_err, d_done} !== 3'b100) begin n_err++; $display("FAIL t1_done got=%b exp=100", {i_done, i_err, d_done}); end
    n_vec++; if (i_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL t1_rdata got=%h exp=deadbeef", i_rdata); end
    n_vec++; if ({mem_ren, mem_wen} !== 2'b00) begin n_err++; $display("FAIL t1_done_mem got=%b exp=00", {mem_ren, mem_wen}); end
    step(); #1;
    n_vec++; if ({i_done, dbg_state} !== 3'b000) begin n_err++; $display("FAIL t1_idle got=%b exp=000", {i_done, dbg_state}); end
  endtask

  task automatic test_d_write_read();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h1234_5678; #1;
    n_vec++; if ({d_ready, i_ready} !== 2'b10) begin n_err++; $display("FAIL t2_wr_ready got=%b exp=10", {d_ready, i_ready}); end
    step(); d_req = 1'b0; #1;
    n_vec++; if ({mem_ren, mem_wen} !== 2'b01) begin n_err++; $display("FAIL t2_wen got=%b exp=01", {mem_ren, mem_wen}); end
    n_vec++; if (mem_din !== 32'h1234_5678) begin n_err++; $display("FAIL t2_din got=%h exp=12345678", mem_din); end
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; #1;
    n_vec++; if ({d_done, d_err} !== 2'b10) begin n_err++; $display("FAIL t2_wr_done got=%b exp=10", {d_done, d_err}); end
    n_vec++; if (d_rdata !== 32'd0) begin n_err++; $display("FAIL t2_wr_rdata got=%h exp=0", d_rdata); end
    n_vec++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL t2_rd_ready got=%h exp=1", d_ready); end
    step(); d_req = 1'b0; #1;
    n_vec++; if ({mem_ren, mem_wen} !== 2'b10) begin n_err++; $display("FAIL t2_ren got=%b exp=10", {mem_ren, mem_wen}); end
    step(); #1;
    n_vec++; if (d_done !== 1'b1) begin n_err++; $display("FAIL t2_rd_done got=%h exp=1", d_done); end
    n_vec++; if (d_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL t2_rd_rdata got=%h exp=12345678", d_rdata); end
    step();
  endtask

  task automatic test_starvation();
    logic exp_d;
    step();
    i_req = 1'b1; i_addr = 32'd1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd2;
    #1;
    for (int g = 0; g < 8; g++) begin
      exp_d = ((g % 4) != 3);
      n_vec++; if ({d_ready, i_ready} !== {exp_d, !exp_d}) begin
        n_err++; $display("FAIL t3_grant%0d got=%b exp=%b", g, {d_ready, i_ready}, {exp_d, !exp_d}); end
      step(); #1;
      n_vec++; if ((mem_ren && mem_wen) || i_ready || d_ready) begin
        n_err++; $display("FAIL t3_access%0d got=%b exp=no_ready_one_strobe", g, {mem_ren, mem_wen, i_ready, d_ready}); end
      step();
      if (g == 7) begin i_req = 1'b0; d_req = 1'b0; end
      #1;
      n_vec++; if ({d_done, i_done} !== {exp_d, !exp_d}) begin
        n_err++; $display("FAIL t3_done%0d got=%b exp=%b", g, {d_done, i_done}, {exp_d, !exp_d}); end
      n_vec++; if ((exp_d ? d_rdata : i_rdata) !== (exp_d ? 32'h2222_2222 : 32'h1111_1111)) begin
        n_err++; $display("FAIL t3_rdata%0d got=%h/%h exp=22222222/11111111", g, d_rdata, i_rdata); end
    end
    step();
  endtask

  task automatic test_d_out_of_range();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; #1;
    n_vec++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL t4_ready got=%h exp=1", d_ready); end
    step(); d_req = 1'b0; #1;
    n_vec++; if ({mem_ren, mem_wen} !== 2'b00) begin n_err++; $display("FAIL t4_mem got=%b exp=00", {mem_ren, mem_wen}); end
    n_vec++; if (mem_addr !== 32'h400) begin n_err++; $display("FAIL t4_addr got=%h exp=400", mem_addr); end
    step(); #1;
    n_vec++; if ({d_done, d_err} !== 2'b11) begin n_err++; $display("FAIL t4_err got=%b exp=11", {d_done, d_err}); end
    n_vec++; if (d_rdata !== 32'h2222_2222) begin n_err++; $display("FAIL t4_rdata got=%h exp=22222222", d_rdata); end
    step();
  endtask

  task automatic test_reset_mid_access();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hCAFE_F00D; #1;
    step(); d_req = 1'b0; d_we = 1'b0; #1;
    n_vec++; if (mem_wen !== 1'b1) begin n_err++; $display("FAIL t5_wen got=%h exp=1", mem_wen); end
    #1; reset = 1'b1; #1;
    n_vec++; if ({mem_ren, mem_wen, d_done, i_done, d_err, i_err} !== 6'b0) begin
      n_err++; $display("FAIL t5_flags got=%b exp=000000", {mem_ren, mem_wen, d_done, i_done, d_err, i_err}); end
    n_vec++; if ({mem_addr, mem_din, i_rdata, d_rdata} !== 128'd0) begin
      n_err++; $display("FAIL t5_data got=%h exp=0", {mem_addr, mem_din, i_rdata, d_rdata}); end
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL t5_state got=%0d exp=0", dbg_state); end
    step(); #1;
    n_vec++; if (d_done !== 1'b0) begin n_err++; $display("FAIL t5_no_done got=%h exp=0", d_done); end
    reset = 1'b0;
    step();
    i_req = 1'b1; i_addr = 32'd5; #1;
    n_vec++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL t5_i_ready got=%h exp=1", i_ready); end
    step(); i_req = 1'b0;
    step(); #1;
    n_vec++; if ({i_done, i_err} !== 2'b10) begin n_err++; $display("FAIL t5_i_done got=%b exp=10", {i_done, i_err}); end
    n_vec++; if (i_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL t5_i_rdata got=%h exp=deadbeef", i_rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    i_req = 1'b1; i_addr = 32'd1; #1;
    n_vec++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL t6_ready_c0 got=%h exp=1", i_ready); end
    step(); i_addr = 32'd2; #1;
    n_vec++; if (i_ready !== 1'b0) begin n_err++; $display("FAIL t6_ready_c1 got=%h exp=0", i_ready); end
    step(); #1;
    n_vec++; if ({i_done, i_ready} !== 2'b11) begin n_err++; $display("FAIL t6_c2 got=%b exp=11", {i_done, i_ready}); end
    n_vec++; if (i_rdata !== 32'h1111_1111) begin n_err++; $display("FAIL t6_rdata1 got=%h exp=11111111", i_rdata); end
    step(); i_req = 1'b0; #1;
    n_vec++; if (mem_addr !== 32'd2) begin n_err++; $display("FAIL t6_addr2 got=%h exp=2", mem_addr); end
    step(); #1;
    n_vec++; if (i_done !== 1'b1) begin n_err++; $display("FAIL t6_done2 got=%h exp=1", i_done); end
    n_vec++; if (i_rdata !== 32'h2222_2222) begin n_err++; $display("FAIL t6_rdata2 got=%h exp=22222222", i_rdata); end
    step();
  endtask

  initial begin
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    preload(10'd5,    32'hDEAD_BEEF);
    preload(10'd1,    32'h1111_1111);
    preload(10'd2,    32'h2222_2222);
    preload(10'h10,   32'h0000_0000);
    preload(10'h20,   32'h0000_0000);
    test_reset();
    test_i_read();
    test_d_write_read();
    test_starvation();
    test_d_out_of_range();
    test_reset_mid_access();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
